// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               FSM state encoding, bubble-count encoding, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

   localparam int RW_DEFAULT      = 5;
   localparam int MD_MAXW_DEFAULT = 6;

   // Controller sequencing states
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BUBBLE  = 2'd1,
      MD_WAIT = 2'd2
   } state_t;

   // Number of bubbles an ID-stage hazard needs
   localparam logic [1:0] BUBBLES_NONE = 2'd0;
   localparam logic [1:0] BUBBLES_ONE  = 2'd1;
   localparam logic [1:0] BUBBLES_TWO  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational ID-stage hazard detector. Compares the ID source
//               registers with the EX/MEM destinations and reports how many
//               bubbles the instruction in ID needs (0, 1 or 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RW = RW_DEFAULT
) (
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic          id_branch,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_regwrite,
   input  logic          ex_memread,
   input  logic [RW-1:0] mem_rd,
   input  logic          mem_memread,
   output logic [1:0]    bubbles
);

   logic ex_hit;
   logic mem_hit;

   // Register $0 is hard-wired, so it never creates a dependency
   assign ex_hit  = (id_use_rs && (id_rs != '0) && (id_rs == ex_rd)) ||
                    (id_use_rt && (id_rt != '0) && (id_rt == ex_rd));
   assign mem_hit = (id_use_rs && (id_rs != '0) && (id_rs == mem_rd)) ||
                    (id_use_rt && (id_rt != '0) && (id_rt == mem_rd));

   // Load-use dominates; a branch behind a load waits for the data to reach WB
   always_comb begin
      bubbles = BUBBLES_NONE;
      if (ex_memread && ex_hit) begin
         bubbles = id_branch ? BUBBLES_TWO : BUBBLES_ONE;
      end else if (id_branch && ex_regwrite && ex_hit) begin
         bubbles = BUBBLES_ONE;
      end else if (id_branch && mem_memread && mem_hit) begin
         bubbles = BUBBLES_ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hold/clear controller for a 5-stage pipeline. Sequences
//               load-use and branch-operand bubbles, multi-cycle mul/div waits
//               (with watchdog) and data-memory freezes.
//               Optional feature macro: HAZARD_PERF_EN adds saturating
//               stall / flush / freeze performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RW      = RW_DEFAULT,
   parameter int MD_MAXW = MD_MAXW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic          id_branch,
   input  logic          branch_taken,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_regwrite,
   input  logic          ex_memread,
   input  logic [RW-1:0] mem_rd,
   input  logic          mem_memread,
   input  logic          md_start,
   input  logic          md_done,
   input  logic          dmem_wait,
   output logic          pc_hold,
   output logic          ifid_hold,
   output logic          idex_hold,
   output logic          exmem_hold,
   output logic          memwb_hold,
   output logic          ifid_clear,
   output logic          idex_clear,
   output logic          exmem_clear,
   output logic          memwb_clear,
   output logic          md_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]   perf_stall,
   output logic [31:0]   perf_flush,
   output logic [31:0]   perf_freeze
`endif
);

   // Last watchdog value before saturation; stepping past it times out
   localparam logic [MD_MAXW-1:0] WD_LAST = {{(MD_MAXW-1){1'b1}}, 1'b0};
   localparam logic [MD_MAXW-1:0] WD_ONE  = {{(MD_MAXW-1){1'b0}}, 1'b1};

   state_t             state, state_nx;
   logic [1:0]         cnt, cnt_nx;
   logic [MD_MAXW-1:0] wd, wd_nx;
   logic [1:0]         bubbles;
   logic               timeout_set;
   logic               stall;
   logic               flush;

   hazard_detect #(
      .RW (RW)
   ) u_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_branch   (id_branch),
      .ex_rd       (ex_rd),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .mem_rd      (mem_rd),
      .mem_memread (mem_memread),
      .bubbles     (bubbles)
   );

   // Next-state and hold/clear decode; dmem_wait freezes everything
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      wd_nx       = wd;
      timeout_set = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_hold   = 1'b0;
      exmem_hold  = 1'b0;
      memwb_hold  = 1'b0;
      ifid_clear  = 1'b0;
      idex_clear  = 1'b0;
      exmem_clear = 1'b0;
      memwb_clear = 1'b0;

      if (dmem_wait) begin
         pc_hold    = 1'b1;
         ifid_hold  = 1'b1;
         idex_hold  = 1'b1;
         exmem_hold = 1'b1;
         memwb_hold = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (bubbles != BUBBLES_NONE) begin
                  stall  = 1'b1;
                  cnt_nx = bubbles - 2'd1;
                  if (bubbles == BUBBLES_TWO) begin
                     state_nx = BUBBLE;
                  end
               end else if (branch_taken) begin
                  flush = 1'b1;
               end
               // A mul/div issue takes over regardless of any bubble need
               if (md_start) begin
                  state_nx = MD_WAIT;
                  wd_nx    = '0;
               end
            end
            BUBBLE: begin
               stall = 1'b1;
               if (cnt > 2'd1) begin
                  cnt_nx = cnt - 2'd1;
               end else begin
                  cnt_nx   = 2'd0;
                  state_nx = RUN;
               end
            end
            MD_WAIT: begin
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_hold   = 1'b1;
               exmem_clear = 1'b1;
               if (md_done) begin
                  state_nx = RUN;
                  wd_nx    = '0;
               end else if (wd == WD_LAST) begin
                  wd_nx       = wd + WD_ONE;
                  timeout_set = 1'b1;
                  state_nx    = RUN;
               end else begin
                  wd_nx = wd + WD_ONE;
               end
            end
            default: begin
               state_nx = RUN;
            end
         endcase

         if (stall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_clear = 1'b1;
         end
         if (flush) begin
            ifid_clear = 1'b1;
         end
      end

      // Reset flushes every pipeline register immediately
      if (!rst_n) begin
         pc_hold     = 1'b0;
         ifid_hold   = 1'b0;
         idex_hold   = 1'b0;
         exmem_hold  = 1'b0;
         memwb_hold  = 1'b0;
         ifid_clear  = 1'b1;
         idex_clear  = 1'b1;
         exmem_clear = 1'b1;
         memwb_clear = 1'b1;
      end
   end

   // State, bubble counter, watchdog and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         cnt        <= 2'd0;
         wd         <= '0;
         md_timeout <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         wd    <= wd_nx;
         if (timeout_set) begin
            md_timeout <= 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating event counters for stall, flush and freeze cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall  <= 32'd0;
         perf_flush  <= 32'd0;
         perf_freeze <= 32'd0;
      end else begin
         if (stall && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
         if (flush && (perf_flush != 32'hFFFF_FFFF)) begin
            perf_flush <= perf_flush + 32'd1;
         end
         if (dmem_wait && (perf_freeze != 32'hFFFF_FFFF)) begin
            perf_freeze <= perf_freeze + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl: directed vector
//               table, multi-cycle corner sequences, and randomized traffic
//               checked against a cycle-level behavioural model.
//               HAZARD_PERF_EN, when defined, also checks the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int RW      = 5;
   localparam int MD_MAXW = 6;
   localparam int WD_LIM  = (1 << MD_MAXW) - 1;

   // Output vector: {pc,ifid,idex,exmem,memwb hold, ifid,idex,exmem,memwb clear, md_timeout}
   localparam logic [9:0] IDLE   = 10'b00000_0000_0;
   localparam logic [9:0] STALL  = 10'b11000_0100_0;
   localparam logic [9:0] FLUSH  = 10'b00000_1000_0;
   localparam logic [9:0] FREEZE = 10'b11111_0000_0;
   localparam logic [9:0] MDH    = 10'b11100_0010_0;
   localparam logic [9:0] RSTO   = 10'b00000_1111_0;
   localparam logic [9:0] TMO    = 10'b00000_0000_1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] id_rs, id_rt, ex_rd, mem_rd;
   logic          id_use_rs, id_use_rt, id_branch, branch_taken;
   logic          ex_regwrite, ex_memread, mem_memread;
   logic          md_start, md_done, dmem_wait;
   logic          pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
   logic          ifid_clear, idex_clear, exmem_clear, memwb_clear, md_timeout;
   logic [9:0]    outs;
`ifdef HAZARD_PERF_EN
   logic [31:0]   perf_stall, perf_flush, perf_freeze;
`endif

   int nvec = 0;
   int nmis = 0;

   // Behavioural model state
   int m_pending;
   bit m_in_md;
   int m_md_age;
   bit m_timeout;
   int m_ps, m_pf, m_pz;

   always #5 clk = ~clk;

   assign outs = {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
                  ifid_clear, idex_clear, exmem_clear, memwb_clear, md_timeout};

   pipe_hazard_ctrl #(
      .RW      (RW),
      .MD_MAXW (MD_MAXW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_branch    (id_branch),
      .branch_taken (branch_taken),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_rd       (mem_rd),
      .mem_memread  (mem_memread),
      .md_start     (md_start),
      .md_done      (md_done),
      .dmem_wait    (dmem_wait),
      .pc_hold      (pc_hold),
      .ifid_hold    (ifid_hold),
      .idex_hold    (idex_hold),
      .exmem_hold   (exmem_hold),
      .memwb_hold   (memwb_hold),
      .ifid_clear   (ifid_clear),
      .idex_clear   (idex_clear),
      .exmem_clear  (exmem_clear),
      .memwb_clear  (memwb_clear),
      .md_timeout   (md_timeout)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush),
      .perf_freeze  (perf_freeze)
`endif
   );

   typedef struct {
      logic [RW-1:0] rs, rt, exrd, memrd;
      logic use_rs, use_rt, br, taken, exrw, exmr, memmr, mds, dmw;
      logic [9:0] exp;
   } vec_t;

   vec_t vt[12];

   function automatic vec_t mk(input int rs, input int rt, input bit urs, input bit urt,
                               input bit br, input bit tk, input int exrd, input bit exrw,
                               input bit exmr, input int memrd, input bit memmr,
                               input bit mds, input bit dmw, input logic [9:0] exp);
      vec_t v;
      v.rs = RW'(rs);   v.rt = RW'(rt);   v.use_rs = urs; v.use_rt = urt;
      v.br = br;        v.taken = tk;     v.exrd = RW'(exrd);
      v.exrw = exrw;    v.exmr = exmr;    v.memrd = RW'(memrd);
      v.memmr = memmr;  v.mds = mds;      v.dmw = dmw;    v.exp = exp;
      return v;
   endfunction

   task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic check32(input string nm, input logic [31:0] act, input int exp);
      nvec++;
      if (act !== 32'(exp)) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Bubbles owed by the ID instruction, straight from the hazard rules
   function automatic int need();
      bit ex_dep  = (id_use_rs && id_rs != 0 && id_rs == ex_rd) ||
                    (id_use_rt && id_rt != 0 && id_rt == ex_rd);
      bit mem_dep = (id_use_rs && id_rs != 0 && id_rs == mem_rd) ||
                    (id_use_rt && id_rt != 0 && id_rt == mem_rd);
      if (ex_memread && ex_dep) return id_branch ? 2 : 1;
      if (id_branch && ex_regwrite && ex_dep) return 1;
      if (id_branch && mem_memread && mem_dep) return 1;
      return 0;
   endfunction

   function automatic logic [9:0] model_exp();
      logic [9:0] e;
      if (!rst_n)                        e = RSTO;
      else if (dmem_wait)                e = FREEZE;
      else if (m_in_md)                  e = MDH;
      else if (m_pending > 0 || need() > 0) e = STALL;
      else if (branch_taken)             e = FLUSH;
      else                               e = IDLE;
      e[0] = rst_n ? m_timeout : 1'b0;
      return e;
   endfunction

   task automatic model_reset();
      m_pending = 0; m_in_md = 0; m_md_age = 0; m_timeout = 0;
      m_ps = 0; m_pf = 0; m_pz = 0;
   endtask

   // Advance the model across one rising clock edge
   task automatic model_update();
      int n;
      if (!rst_n) begin
         model_reset();
      end else if (dmem_wait) begin
         m_pz++;
      end else if (m_in_md) begin
         m_md_age++;
         if (md_done) m_in_md = 0;
         else if (m_md_age == WD_LIM) begin
            m_timeout = 1;
            m_in_md   = 0;
         end
      end else if (m_pending > 0) begin
         m_pending--;
         m_ps++;
      end else begin
         n = need();
         if (n > 0) m_ps++;
         else if (branch_taken) m_pf++;
         if (md_start) begin
            m_in_md  = 1;
            m_md_age = 0;
         end else if (n > 0) begin
            m_pending = n - 1;
         end
      end
   endtask

   // Sample at the falling edge, compare, then cross the next rising edge
   task automatic step(input string nm, input bit has_t, input logic [9:0] texp);
      @(negedge clk);
      if (has_t) check({nm, "_dir"}, outs, texp);
      check(nm, outs, model_exp());
`ifdef HAZARD_PERF_EN
      check32({nm, "_pstall"}, perf_stall, m_ps);
      check32({nm, "_pflush"}, perf_flush, m_pf);
      check32({nm, "_pfreeze"}, perf_freeze, m_pz);
`endif
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
      branch_taken = 0; ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
      mem_rd = '0; mem_memread = 0; md_start = 0; md_done = 0; dmem_wait = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clr_inputs();
      step("reset", 1, RSTO);
      rst_n = 1;
   endtask

   task automatic apply(input vec_t v);
      id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
      id_branch = v.br; branch_taken = v.taken; ex_rd = v.exrd;
      ex_regwrite = v.exrw; ex_memread = v.exmr; mem_rd = v.memrd;
      mem_memread = v.memmr; md_start = v.mds; md_done = 0; dmem_wait = v.dmw;
   endtask

   initial begin
      rst_n = 0;
      clr_inputs();
      model_reset();

      //        rs rt urs urt br tk exrd rw mr memrd mmr mds dmw exp
      vt[0]  = mk(1, 3, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, STALL);  // load-use on rs
      vt[1]  = mk(2, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, IDLE);   // rt not read
      vt[2]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, IDLE);   // $0 never matches
      vt[3]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, FLUSH);  // taken, no hazard
      vt[4]  = mk(4, 5, 1, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, STALL);  // stall masks flush
      vt[5]  = mk(6, 7, 1, 1, 1, 0, 6, 1, 0, 0, 0, 0, 0, STALL);  // branch on ALU result
      vt[6]  = mk(6, 7, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, IDLE);   // ALU result forwarded
      vt[7]  = mk(8, 9, 1, 1, 1, 0, 0, 0, 0, 9, 1, 0, 0, STALL);  // branch on load in MEM
      vt[8]  = mk(8, 9, 1, 1, 1, 0, 0, 0, 0, 9, 0, 0, 0, IDLE);   // MEM not a load
      vt[9]  = mk(1, 3, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, FREEZE); // dmem_wait wins
      vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IDLE);   // md issue cycle
      vt[11] = mk(3, 3, 0, 0, 1, 1, 3, 1, 1, 3, 1, 0, 0, FLUSH);  // no use bits

      do_reset();
      for (int i = 0; i < 12; i++) begin
         do_reset();
         apply(vt[i]);
         step($sformatf("vec%0d", i), 1, vt[i].exp);
      end

      // Load-use: one bubble, then lw moves on to MEM
      do_reset();
      ex_memread = 1; ex_regwrite = 1; ex_rd = 1; id_rs = 1; id_rt = 3;
      id_use_rs = 1; id_use_rt = 1;
      step("lu_stall", 1, STALL);
      clr_inputs(); mem_rd = 1; mem_memread = 1; id_rs = 1; id_use_rs = 1;
      step("lu_after", 1, IDLE);

      // Branch on a load in EX: two bubbles back to back
      do_reset();
      ex_memread = 1; ex_regwrite = 1; ex_rd = 1; id_rs = 1; id_rt = 0;
      id_use_rs = 1; id_use_rt = 1; id_branch = 1;
      step("lub_stall0", 1, STALL);
      step("lub_stall1", 1, STALL);
      clr_inputs();
      step("lub_after", 1, IDLE);

      // $0 load never stalls; taken branch flushes exactly one cycle
      do_reset();
      ex_memread = 1; ex_rd = 0; id_use_rs = 1; id_use_rt = 1;
      step("z_nostall", 1, IDLE);
      branch_taken = 1;
      step("z_flush", 1, FLUSH);
      branch_taken = 0;
      step("z_after", 1, IDLE);

      // Mul/div released by md_done after five wait cycles
      do_reset();
      md_start = 1;
      step("md_issue", 1, IDLE);
      md_start = 0;
      for (int i = 0; i < 4; i++) step($sformatf("md_wait%0d", i), 1, MDH);
      md_done = 1;
      step("md_done", 1, MDH);
      md_done = 0;
      step("md_after", 1, IDLE);

      // Mul/div watchdog: 63 wait cycles, then sticky timeout
      md_start = 1;
      step("wd_issue", 1, IDLE);
      md_start = 0;
      for (int i = 0; i < WD_LIM; i++) step($sformatf("wd_wait%0d", i), 1, MDH);
      step("wd_timeout", 1, TMO);
      step("wd_sticky", 1, TMO);

      // Memory freeze inside a two-bubble sequence
      do_reset();
      ex_memread = 1; ex_rd = 2; id_rs = 2; id_use_rs = 1; id_branch = 1;
      step("fz_stall0", 1, STALL);
      clr_inputs(); dmem_wait = 1;
      for (int i = 0; i < 3; i++) step($sformatf("fz_freeze%0d", i), 1, FREEZE);
      dmem_wait = 0;
      step("fz_resume", 1, STALL);
      step("fz_after", 1, IDLE);

      // Asynchronous reset in the middle of a mul/div wait
      do_reset();
      md_start = 1;
      step("ar_issue", 1, IDLE);
      md_start = 0;
      step("ar_wait", 1, MDH);
      rst_n = 0;
      #2;
      check("ar_async", outs, RSTO);
      model_reset();
      step("ar_hold", 1, RSTO);
      rst_n = 1;
      step("ar_run", 1, IDLE);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n        = ($urandom_range(0, 299) != 0);
         id_rs        = RW'($urandom_range(0, 3));
         id_rt        = RW'($urandom_range(0, 3));
         id_use_rs    = $urandom_range(0, 1) == 1;
         id_use_rt    = $urandom_range(0, 1) == 1;
         id_branch    = $urandom_range(0, 2) == 0;
         branch_taken = $urandom_range(0, 3) == 0;
         ex_rd        = RW'($urandom_range(0, 3));
         ex_regwrite  = $urandom_range(0, 1) == 1;
         ex_memread   = $urandom_range(0, 2) == 0;
         mem_rd       = RW'($urandom_range(0, 3));
         mem_memread  = $urandom_range(0, 1) == 1;
         md_start     = $urandom_range(0, 15) == 0;
         md_done      = $urandom_range(0, 5) == 0;
         dmem_wait    = $urandom_range(0, 7) == 0;
         step("rand", 0, IDLE);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

`default_nettype wire
